// File: rtl/keypad_entry.sv
// Keypad digit entry: synchronises and debounces a one-hot button bank,
// decodes single-key presses and shifts the digit into a multi-digit
// entry register when the key is released.
module keypad_entry #(
  parameter int                 NUM_KEYS        = 10,
  parameter int                 NUM_DIGITS      = 4,
  parameter int                 DIGIT_W         = 4,
  parameter logic [DIGIT_W-1:0] BLANK_CODE      = 4'hA,
  parameter int                 DEBOUNCE_CYCLES = 4,
  parameter bit                 OVERWRITE       = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_KEYS-1:0]                keypad_buttons,
  input  logic                               clear_entry,
  output logic [NUM_DIGITS*DIGIT_W-1:0]      keypad_values,
  output logic                               shift_pulse,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
  output logic                               entry_full,
  output logic                               invalid_press
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]               DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]              CNT_MAX   = CNT_W'(NUM_DIGITS);
  localparam logic [NUM_DIGITS*DIGIT_W-1:0] BLANK_ALL = {NUM_DIGITS{BLANK_CODE}};

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    WAIT_RELEASE
  } state_t;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, deb_q;
  logic [DB_W-1:0]     db_cnt_q;

  state_t                        state_q, state_d;
  logic [DIGIT_W-1:0]            code_q, code_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] values_q, values_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          shift_q, shift_d;
  logic                          invalid_q, invalid_d;
  logic                          full_q;

  logic               one_hot, multi_hot, none_hot, commit, full_now;
  logic [DIGIT_W-1:0] key_idx;

  // Two-flop synchroniser followed by a whole-vector stability counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= keypad_buttons;
      sync2_q <= sync1_q;
      // sync1 != sync2 means the synchronised vector is changing this edge.
      if ((sync1_q != sync2_q) || (sync2_q == deb_q)) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        deb_q    <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // Classify the debounced vector and find the index of the pressed key.
  always_comb begin
    none_hot  = (deb_q == '0);
    one_hot   = $onehot(deb_q);
    multi_hot = !$onehot0(deb_q);
    key_idx   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (deb_q[i]) key_idx = DIGIT_W'(i);
    end
  end

  // Press FSM next state plus entry-register, count and strobe updates.
  // NOTE: every signal gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    values_d  = values_q;
    count_d   = count_q;
    shift_d   = 1'b0;
    invalid_d = 1'b0;
    commit    = 1'b0;
    full_now  = (count_q == CNT_MAX);

    unique case (state_q)
      IDLE: begin
        if (one_hot) begin
          code_d  = key_idx;
          state_d = HELD;
        end else if (multi_hot) begin
          invalid_d = 1'b1;
          state_d   = WAIT_RELEASE;
        end
      end
      HELD: begin
        if (multi_hot) begin
          invalid_d = 1'b1;
          state_d   = WAIT_RELEASE;
        end else if (none_hot) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_RELEASE: begin
        if (none_hot) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      if (full_now && !OVERWRITE) begin
        invalid_d = 1'b1;
      end else begin
        values_d = {values_q[(NUM_DIGITS-1)*DIGIT_W-1:0], code_q};
        shift_d  = 1'b1;
        if (!full_now) count_d = count_q + CNT_W'(1);
      end
    end

    // Clear overrides any commit; a key still held must be released first.
    if (clear_entry) begin
      values_d = BLANK_ALL;
      count_d  = '0;
      shift_d  = 1'b0;
      if (state_q == HELD) begin
        state_d   = WAIT_RELEASE;
        invalid_d = 1'b0;
      end
    end
  end

  // Register FSM state, entry register and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      code_q    <= '0;
      values_q  <= BLANK_ALL;
      count_q   <= '0;
      shift_q   <= 1'b0;
      invalid_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      values_q  <= values_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      invalid_q <= invalid_d;
      full_q    <= (count_d == CNT_MAX);
    end
  end

  assign keypad_values = values_q;
  assign shift_pulse   = shift_q;
  assign digit_count   = count_q;
  assign entry_full    = full_q;
  assign invalid_press = invalid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: one instance with overwrite enabled
// and one with overwrite disabled, sharing the same button stimulus.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  keypad_buttons;
  logic        clear_entry;

  logic [15:0] vals_a, vals_b;
  logic        shift_a, shift_b, inv_a, inv_b, full_a, full_b;
  logic [2:0]  cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;
  int n_shift_a = 0, n_inv_a = 0, n_shift_b = 0, n_inv_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  keypad_entry #(.OVERWRITE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .keypad_buttons(keypad_buttons),
    .clear_entry(clear_entry), .keypad_values(vals_a), .shift_pulse(shift_a),
    .digit_count(cnt_a), .entry_full(full_a), .invalid_press(inv_a)
  );

  keypad_entry #(.OVERWRITE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .keypad_buttons(keypad_buttons),
    .clear_entry(clear_entry), .keypad_values(vals_b), .shift_pulse(shift_b),
    .digit_count(cnt_b), .entry_full(full_b), .invalid_press(inv_b)
  );

  always #5 clk = ~clk;

  // Count strobes and police the strobe rules on the falling edge.
  always @(negedge clk) begin
    if (shift_a) n_shift_a++;
    if (inv_a)   n_inv_a++;
    if (shift_b) n_shift_b++;
    if (inv_b)   n_inv_b++;
    if ((shift_a && inv_a) || ((shift_a || inv_a) && prev_a)) begin
      checks++;
      errors++;
      $display("FAIL strobe_rule_a: shift=%0b invalid=%0b prev=%0b required no overlap", shift_a, inv_a, prev_a);
    end
    if ((shift_b && inv_b) || ((shift_b || inv_b) && prev_b)) begin
      checks++;
      errors++;
      $display("FAIL strobe_rule_b: shift=%0b invalid=%0b prev=%0b required no overlap", shift_b, inv_b, prev_b);
    end
    prev_a = shift_a || inv_a;
    prev_b = shift_b || inv_b;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    keypad_buttons = '0;
    clear_entry    = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic press_release(input int key, input int hold);
    keypad_buttons      = '0;
    keypad_buttons[key] = 1'b1;
    tick(hold);
    keypad_buttons = '0;
    tick(12);
  endtask

  typedef struct {
    int          key;
    logic [15:0] val_a;
    int          cnt_a;
    logic        full_a;
    logic [15:0] val_b;
    int          shift_b;
    int          inv_b;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    int sa, ia, sb, ib;

    vecs[0] = '{1, 16'hAAA1, 1, 1'b0, 16'hAAA1, 1, 0};
    vecs[1] = '{2, 16'hAA12, 2, 1'b0, 16'hAA12, 1, 0};
    vecs[2] = '{3, 16'hA123, 3, 1'b0, 16'hA123, 1, 0};
    vecs[3] = '{4, 16'h1234, 4, 1'b1, 16'h1234, 1, 0};
    vecs[4] = '{5, 16'h2345, 4, 1'b1, 16'h1234, 0, 1};

    // Reset state.
    do_reset();
    check("rst_values", vals_a, 16'hAAAA);
    check("rst_count",  cnt_a,  0);
    check("rst_full",   full_a, 0);
    check("rst_shift",  shift_a, 0);
    check("rst_invalid", inv_a, 0);

    // Single press of key 3 with release latency measurement.
    sa = n_shift_a; ia = n_inv_a;
    keypad_buttons[3] = 1'b1;
    tick(20);
    keypad_buttons = '0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (shift_a && lat == 0) lat = i;
    end
    check("release_latency", lat, 7);
    check("k3_shift_count", n_shift_a - sa, 1);
    check("k3_invalid_count", n_inv_a - ia, 0);
    check("k3_values", vals_a, 16'hAAA3);
    check("k3_count", cnt_a, 1);
    check("k3_full", full_a, 0);

    // Five presses: overwrite vs reject when full.
    do_reset();
    for (int v = 0; v < 5; v++) begin
      sa = n_shift_a; ia = n_inv_a; sb = n_shift_b; ib = n_inv_b;
      press_release(vecs[v].key, 15);
      check($sformatf("seq%0d_values_a", v), vals_a, vecs[v].val_a);
      check($sformatf("seq%0d_count_a", v),  cnt_a,  vecs[v].cnt_a);
      check($sformatf("seq%0d_full_a", v),   full_a, vecs[v].full_a);
      check($sformatf("seq%0d_shift_a", v),  n_shift_a - sa, 1);
      check($sformatf("seq%0d_inv_a", v),    n_inv_a - ia, 0);
      check($sformatf("seq%0d_values_b", v), vals_b, vecs[v].val_b);
      check($sformatf("seq%0d_shift_b", v),  n_shift_b - sb, vecs[v].shift_b);
      check($sformatf("seq%0d_inv_b", v),    n_inv_b - ib, vecs[v].inv_b);
    end
    check("nw_full_count_b", cnt_b, 4);

    // Key 7 with short glitches on press and release.
    do_reset();
    sa = n_shift_a; ia = n_inv_a;
    keypad_buttons[7] = 1'b1; tick(2);
    keypad_buttons = '0;      tick(2);
    keypad_buttons[7] = 1'b1; tick(15);
    keypad_buttons = '0;      tick(2);
    keypad_buttons[7] = 1'b1; tick(2);
    keypad_buttons = '0;      tick(15);
    check("glitch_shift_count", n_shift_a - sa, 1);
    check("glitch_invalid_count", n_inv_a - ia, 0);
    check("glitch_values", vals_a, 16'hAAA7);

    // Chord: key 2 held, key 5 added, both released.
    sa = n_shift_a; ia = n_inv_a;
    keypad_buttons[2] = 1'b1; tick(10);
    keypad_buttons[5] = 1'b1; tick(10);
    keypad_buttons = '0;      tick(15);
    check("chord_invalid_count", n_inv_a - ia, 1);
    check("chord_shift_count", n_shift_a - sa, 0);
    check("chord_values", vals_a, 16'hAAA7);
    check("chord_count", cnt_a, 1);
    press_release(1, 15);
    check("after_chord_values", vals_a, 16'hAA71);
    check("after_chord_count", cnt_a, 2);

    // Clear while key 9 is held.
    do_reset();
    press_release(6, 15);
    check("pre_clear_values", vals_a, 16'hAAA6);
    sa = n_shift_a;
    keypad_buttons[9] = 1'b1; tick(10);
    clear_entry = 1'b1; tick(1);
    clear_entry = 1'b0;
    check("clear_values_now", vals_a, 16'hAAAA);
    check("clear_count_now", cnt_a, 0);
    tick(5);
    keypad_buttons = '0; tick(15);
    check("clear_shift_count", n_shift_a - sa, 0);
    check("clear_values", vals_a, 16'hAAAA);
    check("clear_count", cnt_a, 0);
    press_release(0, 15);
    check("post_clear_values", vals_a, 16'hAAA0);
    check("post_clear_count", cnt_a, 1);

    // Reset while key 4 is held with two digits entered.
    do_reset();
    press_release(1, 15);
    press_release(2, 15);
    check("pre_reset_values", vals_a, 16'hAA12);
    check("pre_reset_count", cnt_a, 2);
    keypad_buttons[4] = 1'b1; tick(10);
    reset = 1'b1; tick(1);
    check("midreset_values", vals_a, 16'hAAAA);
    check("midreset_count", cnt_a, 0);
    check("midreset_full", full_a, 0);
    check("midreset_strobes", {30'd0, shift_a, inv_a}, 0);
    keypad_buttons = '0; tick(1);
    reset = 1'b0;
    sa = n_shift_a;
    tick(15);
    check("post_reset_no_commit", n_shift_a - sa, 0);
    press_release(4, 15);
    check("repress_values", vals_a, 16'hAAA4);
    check("repress_count", cnt_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
